// File: rtl/poly_div_7bit.sv
// GF(2) polynomial divider a = b*q ^ r: one quotient bit per clock, N RUN cycles plus one DONE cycle per division.
// start is ignored while busy; macro POLY_DIV_ERR_EN adds err, which flags a non-monic divisor and skips RUN.
module poly_div_7bit #(
  parameter int N = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-2:0] a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   q,
  output logic [N-2:0]   r
`ifdef POLY_DIV_ERR_EN
  ,
  output logic           err
`endif
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-2:0]  rem_q, rem_d;
  logic [N-1:0]  a_lo_q, a_lo_d;
  logic [N-2:0]  b_lo_q, b_lo_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-2:0]  r_q, r_d;
  logic          err_q, err_d;
  logic [N-1:0]  t;

  // Partial remainder with the next dividend bit shifted in; its MSB is the quotient bit.
  assign t = {rem_q, a_lo_q[cnt_q]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    a_lo_d  = a_lo_q;
    b_lo_d  = b_lo_q;
    quot_d  = quot_q;
    q_d     = q_q;
    r_d     = r_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          a_lo_d  = a[N-1:0];
          b_lo_d  = b[N-2:0];
          rem_d   = a[2*N-2:N];
          cnt_d   = CW'(N-1);
          quot_d  = '0;
          state_d = RUN;
`ifdef POLY_DIV_ERR_EN
          if (!b[N-1]) begin
            err_d   = 1'b1;
            q_d     = '0;
            r_d     = '0;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        quot_d = {quot_q[N-2:0], t[N-1]};
        rem_d  = t[N-2:0] ^ (t[N-1] ? b_lo_q : '0);
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          q_d     = quot_d;
          r_d     = rem_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      a_lo_q  <= '0;
      b_lo_q  <= '0;
      quot_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      a_lo_q  <= a_lo_d;
      b_lo_q  <= b_lo_d;
      quot_q  <= quot_d;
      q_q     <= q_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign q    = q_q;
  assign r    = r_q;

`ifdef POLY_DIV_ERR_EN
  assign err = err_q;
`else
  // Leading coefficient is implied to be 1, so b[N-1] is never read.
  logic unused_b_msb;
  assign unused_b_msb = b[N-1] | err_q;
`endif

endmodule

// File: tb/tb_poly_div_7bit.sv
// Scoreboard bench for poly_div_7bit: directed vectors plus clmul-checked random vectors.
module tb_poly_div_7bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [12:0] a;
  logic [6:0]  b;
  logic        busy, done;
  logic [6:0]  q;
  logic [5:0]  r;
`ifdef POLY_DIV_ERR_EN
  logic        err;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [12:0] a;
    logic [6:0]  b;
    logic [6:0]  q;
    logic [5:0]  r;
    logic        err;
    bit          directed;
  } exp_t;

  exp_t sb[$];

  poly_div_7bit #(.N(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r)
`ifdef POLY_DIV_ERR_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] clmul(input logic [6:0] x, input logic [6:0] y);
    logic [12:0] p;
    p = '0;
    for (int i = 0; i < 7; i++)
      if (y[i]) p = p ^ (13'(x) << i);
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: q=%h r=%h with nothing outstanding", q, r);
      end else begin
        exp_t e;
        bit   ok;
        e = sb.pop_front();
        if (e.directed) ok = (q === e.q) && (r === e.r);
        else            ok = ((clmul(e.b | 7'h40, q) ^ 13'(r)) === e.a);
`ifdef POLY_DIV_ERR_EN
        ok = ok && (err === e.err);
`endif
        if (!ok) begin
          fails++;
          $display("FAIL result a=%h b=%h: got q=%h r=%h expected q=%h r=%h err=%b", e.a, e.b, q, r, e.q, e.r, e.err);
        end
      end
    end
  end

  task automatic push(input logic [12:0] av, input logic [6:0] bv, input logic [6:0] eq,
                      input logic [5:0] er, input logic ee, input bit dir);
    exp_t e;
    e.a = av; e.b = bv; e.q = eq; e.r = er; e.err = ee; e.directed = dir;
    sb.push_back(e);
  endtask

  task automatic drain(input int maxc);
    int k;
    k = 0;
    while (sb.size() != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding after %0d cycles", sb.size(), maxc);
      sb.delete();
    end
  endtask

  // One start pulse; a and b are scrambled right after the accepting edge.
  task automatic issue(input logic [12:0] av, input logic [6:0] bv, input logic [6:0] eq,
                       input logic [5:0] er, input logic ee, input bit dir);
    push(av, bv, eq, er, ee, dir);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 13'($urandom);
    b = 7'($urandom);
    drain(30);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t1, t2, nd;
    logic [12:0] ra;
    logic [6:0]  rb;

    start = 1'b0; a = '0; b = '0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_q",    32'(q),    32'd0);
    chk("reset_r",    32'(r),    32'd0);
    rst_n = 1'b1;

    // Reference vector with busy/done timing.
    push(13'h025E, 7'h43, 7'h09, 6'h05, 1'b0, 1'b1);
    @(negedge clk);
    a = 13'h025E; b = 7'h43; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 13'h1ABC; b = 7'h15;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) break;
      if (busy) n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'd7);
    chk("busy_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
    drain(5);

    issue(13'h10C0, 7'h43, 7'h40, 6'h00, 1'b0, 1'b1);
    issue(13'h003F, 7'h40, 7'h00, 6'h3F, 1'b0, 1'b1);
    issue(13'h0000, 7'h43, 7'h00, 6'h00, 1'b0, 1'b1);
    issue(13'h1555, 7'h7F, 7'h7F, 6'h00, 1'b0, 1'b1);
    issue(13'h156A, 7'h7F, 7'h7F, 6'h3F, 1'b0, 1'b1);
`ifndef POLY_DIV_ERR_EN
    // Leading coefficient forced to 1: 7'h03 divides like 7'h43.
    issue(13'h025E, 7'h03, 7'h09, 6'h05, 1'b0, 1'b1);
`endif

    // start held high for 20 cycles: accepts at E0, E9, E18.
    repeat (3) push(13'h025E, 7'h43, 7'h09, 6'h05, 1'b0, 1'b1);
    @(negedge clk);
    a = 13'h025E; b = 7'h43; start = 1'b1;
    nd = 0; t1 = -1; t2 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
      end
    end
    start = 1'b0;
    chk("b2b_completions", 32'(nd), 32'd2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd9);
    drain(30);

    // Abort with reset at E3; q holds 7'h09 beforehand.
    @(negedge clk);
    a = 13'h1555; b = 7'h7F; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q",    32'(q),    32'd0);
    chk("abort_r",    32'(r),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    push(13'h10C0, 7'h43, 7'h40, 6'h00, 1'b0, 1'b1);
    a = 13'h10C0; b = 7'h43; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    drain(30);

`ifdef POLY_DIV_ERR_EN
    issue(13'h025E, 7'h21, 7'h00, 6'h00, 1'b1, 1'b1);
    push(13'h025E, 7'h43, 7'h09, 6'h05, 1'b0, 1'b1);
    @(negedge clk);
    a = 13'h025E; b = 7'h43; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    drain(30);
`endif

    for (int v = 0; v < 1000; v++) begin
      ra = 13'($urandom);
      rb = 7'($urandom) | 7'h40;
      issue(ra, rb, 7'h00, 6'h00, 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
